// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter: starts one frame at a time, pops on tx_done_tick.
// Optional sticky overflow flag and its clear input exist only when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic [DBIT-1:0]   w_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_din,
   input  logic              tx_done_tick
`ifdef UART_TX_FIFO_OVF_EN
   ,
   output logic              overflow,
   input  logic              ovf_clr
`endif
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic [DBIT-1:0]   mem [0:DEPTH-1];
   logic              pop, wr_acc;

   assign pop    = (state_q == BUSY) && tx_done_tick;
   // A pop frees the head slot at the same edge, so a full FIFO can still take a write.
   assign wr_acc = wr && (!full_q || pop);

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
      if (pop)    r_ptr_d = r_ptr_q + PTR_ONE;
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   always_comb begin
      state_d  = state_q;
      tx_start = 1'b0;
      case (state_q)
         IDLE:    if (!empty_q) state_d = START;
         START: begin
            tx_start = 1'b1;
            state_d  = BUSY;
         end
         BUSY:    if (tx_done_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[w_ptr_q] <= w_data;
   end

   assign tx_din = mem[r_ptr_q];
   assign full   = full_q;
   assign empty  = empty_q;
   assign count  = count_q;

`ifdef UART_TX_FIFO_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr)               ovf_d = 1'b0;
      if (wr && full_q && !pop)  ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign overflow = ovf_q;
`endif

endmodule
